// File: rtl/reorder_buffer.sv
// Reorder buffer: circular tag ring with in-order allocate/retire, out-of-order CDB
// writeback, mispredict squash of younger entries and full flush.
module reorder_buffer #(
  parameter int  ROB_SIZE     = 16,
  parameter int  DATA_WIDTH   = 64,
  parameter int  CDB_PORTS    = 2,
  parameter int  COMMIT_WIDTH = 2,
  localparam int TW           = $clog2(ROB_SIZE + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               alloc_valid,
  input  logic [4:0]                         alloc_rd,
  input  logic [63:0]                        alloc_pc,
  output logic                               alloc_ready,
  output logic [TW-1:0]                      alloc_tag,
  input  logic [CDB_PORTS-1:0]               cdb_valid,
  input  logic [CDB_PORTS*TW-1:0]            cdb_tag,
  input  logic [CDB_PORTS*DATA_WIDTH-1:0]    cdb_value,
  input  logic                               mispredict,
  input  logic [TW-1:0]                      mispredict_tag,
  input  logic                               flush,
  output logic [COMMIT_WIDTH-1:0]            commit_valid,
  output logic [COMMIT_WIDTH*TW-1:0]         commit_tag,
  output logic [COMMIT_WIDTH*5-1:0]          commit_rd,
  output logic [COMMIT_WIDTH*DATA_WIDTH-1:0] commit_value,
  output logic [TW-1:0]                      rob_count,
  output logic                               rob_full,
  output logic                               rob_empty
);

  localparam logic [TW-1:0] SIZE_T  = TW'(ROB_SIZE);
  localparam logic [TW-1:0] TAG_ONE = TW'(1);

  logic [ROB_SIZE-1:0]     r_valid;
  logic [ROB_SIZE-1:0]     r_done;
  logic [4:0]              r_rd    [ROB_SIZE];
  logic [63:0]             r_pc    [ROB_SIZE];
  logic [DATA_WIDTH-1:0]   r_value [ROB_SIZE];
  logic [TW-1:0]           r_head;
  logic [TW-1:0]           r_tail;
  logic [TW-1:0]           r_count;

  logic                    w_mp_hit;
  logic                    w_alloc;
  logic [ROB_SIZE-1:0]     w_kill;
  logic [ROB_SIZE-1:0]     w_retire;
  logic [COMMIT_WIDTH-1:0] w_commit;
  logic [TW-1:0]           w_commit_cnt;
  logic [TW-1:0]           w_count_nxt;
  logic                    w_pc_unused;

  // Position of entry idx relative to the head: 0 = oldest.
  function automatic int age_of(input int idx, input logic [TW-1:0] head);
    return (idx - (int'(head) - 1) + ROB_SIZE) % ROB_SIZE;
  endfunction

  function automatic logic [TW-1:0] tag_add(input logic [TW-1:0] tag, input int n);
    return TW'((int'(tag) - 1 + n) % ROB_SIZE + 1);
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    int mp_age;
    mp_age   = ROB_SIZE;
    w_mp_hit = 1'b0;
    w_kill   = '0;
    for (int i = 0; i < ROB_SIZE; i++) begin
      if (mispredict && int'(mispredict_tag) == i + 1 && r_valid[i]) begin
        w_mp_hit = 1'b1;
        mp_age   = age_of(i, r_head);
      end
    end
    for (int i = 0; i < ROB_SIZE; i++)
      w_kill[i] = w_mp_hit && r_valid[i] && (age_of(i, r_head) > mp_age);
  end

  // Retire chain from head; squashed entries never retire, so commit and squash stay disjoint.
  always_comb begin
    logic chain;
    int   idx;
    int   cnt;
    chain        = !(reset || flush);
    idx          = 0;
    cnt          = 0;
    w_commit     = '0;
    w_retire     = '0;
    commit_tag   = '0;
    commit_rd    = '0;
    commit_value = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      idx = (int'(r_head) - 1 + k) % ROB_SIZE;
      commit_tag[k*TW +: TW] = TW'(idx + 1);
      for (int i = 0; i < ROB_SIZE; i++) begin
        if (i == idx) begin
          commit_rd[k*5 +: 5]                      = r_rd[i];
          commit_value[k*DATA_WIDTH +: DATA_WIDTH] = r_value[i];
          chain = chain && (k < int'(r_count)) && r_valid[i] && r_done[i] && !w_kill[i];
          w_commit[k] = chain;
          if (chain) w_retire[i] = 1'b1;
        end
      end
      if (w_commit[k]) cnt++;
    end
    w_commit_cnt = TW'(cnt);
  end

  always_comb begin
    int nxt;
    w_alloc = alloc_valid && (r_count < SIZE_T) && !w_mp_hit;
    nxt     = int'(r_count) + (w_alloc ? 1 : 0) - int'(w_commit_cnt);
    for (int i = 0; i < ROB_SIZE; i++)
      if (w_kill[i]) nxt--;
    w_count_nxt = TW'(nxt);
  end

  // The PC is held for debug visibility only; fold it so it is not flagged as dead.
  always_comb begin
    w_pc_unused = 1'b0;
    for (int i = 0; i < ROB_SIZE; i++)
      w_pc_unused = w_pc_unused ^ (^r_pc[i]);
  end

  assign alloc_ready  = reset | (r_count < SIZE_T);
  assign alloc_tag    = reset ? TAG_ONE : r_tail;
  assign commit_valid = w_commit;
  assign rob_count    = r_count;
  assign rob_full     = (r_count == SIZE_T);
  assign rob_empty    = (r_count == '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= TAG_ONE;
      r_tail  <= TAG_ONE;
      r_count <= '0;
    end else begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        for (int p = 0; p < CDB_PORTS; p++)
          if (cdb_valid[p] && int'(cdb_tag[p*TW +: TW]) == i + 1 && r_valid[i])
            r_done[i] <= 1'b1;
        if (w_retire[i] || w_kill[i]) begin
          r_valid[i] <= 1'b0;
          r_done[i]  <= 1'b0;
        end
        if (w_alloc && int'(r_tail) == i + 1) begin
          r_valid[i] <= 1'b1;
          r_done[i]  <= 1'b0;
        end
      end
      r_head <= tag_add(r_head, int'(w_commit_cnt));
      if (w_mp_hit)     r_tail <= tag_add(mispredict_tag, 1);
      else if (w_alloc) r_tail <= tag_add(r_tail, 1);
      r_count <= w_count_nxt;
    end
  end

  // NOTE: payload storage is not reset; valid/done gate every use of it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ROB_SIZE; i++) begin
      for (int p = 0; p < CDB_PORTS; p++)
        if (cdb_valid[p] && int'(cdb_tag[p*TW +: TW]) == i + 1 && r_valid[i])
          r_value[i] <= cdb_value[p*DATA_WIDTH +: DATA_WIDTH];
      if (w_alloc && int'(r_tail) == i + 1) begin
        r_rd[i] <= alloc_rd;
        r_pc[i] <= alloc_pc;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus randomized traffic checked
// against a queue-based program-order model.
module tb_reorder_buffer;

  localparam int RS = 8;
  localparam int DW = 32;
  localparam int CP = 2;
  localparam int CW = 2;
  localparam int TW = 4;

  logic              clk;
  logic              reset;
  logic              alloc_valid;
  logic [4:0]        alloc_rd;
  logic [63:0]       alloc_pc;
  logic              alloc_ready;
  logic [TW-1:0]     alloc_tag;
  logic [CP-1:0]     cdb_valid;
  logic [CP*TW-1:0]  cdb_tag;
  logic [CP*DW-1:0]  cdb_value;
  logic              mispredict;
  logic [TW-1:0]     mispredict_tag;
  logic              flush;
  logic [CW-1:0]     commit_valid;
  logic [CW*TW-1:0]  commit_tag;
  logic [CW*5-1:0]   commit_rd;
  logic [CW*DW-1:0]  commit_value;
  logic [TW-1:0]     rob_count;
  logic              rob_full;
  logic              rob_empty;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  rd;
    logic [31:0] value;
    bit          done;
  } ent_t;

  reorder_buffer #(
    .ROB_SIZE(RS), .DATA_WIDTH(DW), .CDB_PORTS(CP), .COMMIT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag), .flush(flush),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
    .commit_value(commit_value), .rob_count(rob_count), .rob_full(rob_full),
    .rob_empty(rob_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    alloc_valid    = 1'b0;
    alloc_rd       = '0;
    alloc_pc       = '0;
    cdb_valid      = '0;
    cdb_tag        = '0;
    cdb_value      = '0;
    mispredict     = 1'b0;
    mispredict_tag = '0;
    flush          = 1'b0;
  endtask

  task automatic set_cdb(input int p, input int tag, input logic [31:0] v);
    cdb_valid[p]          = 1'b1;
    cdb_tag[p*TW +: TW]   = 4'(tag);
    cdb_value[p*DW +: DW] = v;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      alloc_valid = 1'b1;
      alloc_rd    = 5'(i + 1);
      alloc_pc    = 64'(i) * 64'd4;
      tick();
    end
    alloc_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #1;
    n_total++; if (commit_valid !== 2'b00) $display("FAIL rst_during_cv: got %b want 00", commit_valid); else n_pass++;
    n_total++; if (alloc_ready !== 1'b1) $display("FAIL rst_during_ready: got %b want 1", alloc_ready); else n_pass++;
    n_total++; if (alloc_tag !== 4'd1) $display("FAIL rst_during_tag: got %0d want 1", alloc_tag); else n_pass++;
    tick();
    reset = 1'b0;
    #1;
    n_total++; if (rob_count !== 4'd0) $display("FAIL rst_count: got %0d want 0", rob_count); else n_pass++;
    n_total++; if (rob_empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", rob_empty); else n_pass++;
    n_total++; if (rob_full !== 1'b0) $display("FAIL rst_full: got %b want 0", rob_full); else n_pass++;
    n_total++; if (alloc_tag !== 4'd1) $display("FAIL rst_tag: got %0d want 1", alloc_tag); else n_pass++;
    n_total++; if (commit_valid !== 2'b00) $display("FAIL rst_cv: got %b want 00", commit_valid); else n_pass++;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < RS; i++) begin
      alloc_valid = 1'b1;
      alloc_rd    = 5'(i);
      #1;
      n_total++; if (alloc_tag !== 4'(i + 1)) $display("FAIL fill_tag%0d: got %0d want %0d", i, alloc_tag, i + 1); else n_pass++;
      tick();
    end
    #1;
    n_total++; if (alloc_ready !== 1'b0) $display("FAIL fill_ready: got %b want 0", alloc_ready); else n_pass++;
    n_total++; if (rob_full !== 1'b1) $display("FAIL fill_full: got %b want 1", rob_full); else n_pass++;
    tick();
    alloc_valid = 1'b0;
    #1;
    n_total++; if (rob_count !== 4'd8) $display("FAIL fill_9th_count: got %0d want 8", rob_count); else n_pass++;
    n_total++; if (alloc_tag !== 4'd1) $display("FAIL fill_9th_tail: got %0d want 1", alloc_tag); else n_pass++;
  endtask

  task automatic test_ooo_writeback();
    do_reset();
    alloc_n(3);
    set_cdb(0, 3, 32'h33);
    tick();
    idle();
    set_cdb(0, 1, 32'h11);
    #1;
    n_total++; if (commit_valid !== 2'b00) $display("FAIL ooo_no_fwd1: got %b want 00", commit_valid); else n_pass++;
    tick();
    idle();
    #1;
    n_total++; if (commit_valid !== 2'b01) $display("FAIL ooo_cv1: got %b want 01", commit_valid); else n_pass++;
    n_total++; if ({commit_tag[3:0], commit_rd[4:0], commit_value[31:0]} !== {4'd1, 5'd1, 32'h11})
      $display("FAIL ooo_slot0: got tag %0d rd %0d val %h want 1 1 11", commit_tag[3:0], commit_rd[4:0], commit_value[31:0]); else n_pass++;
    tick();
    set_cdb(1, 2, 32'h22);
    #1;
    n_total++; if (commit_valid !== 2'b00) $display("FAIL ooo_no_fwd2: got %b want 00", commit_valid); else n_pass++;
    tick();
    idle();
    #1;
    n_total++; if (commit_valid !== 2'b11) $display("FAIL ooo_cv2: got %b want 11", commit_valid); else n_pass++;
    n_total++; if ({commit_tag[7:4], commit_tag[3:0]} !== {4'd3, 4'd2})
      $display("FAIL ooo_tags: got %0d,%0d want 2,3", commit_tag[3:0], commit_tag[7:4]); else n_pass++;
    n_total++; if ({commit_value[63:32], commit_value[31:0]} !== {32'h33, 32'h22})
      $display("FAIL ooo_values: got %h,%h want 22,33", commit_value[31:0], commit_value[63:32]); else n_pass++;
    tick();
    #1;
    n_total++; if (rob_empty !== 1'b1) $display("FAIL ooo_empty: got %b want 1", rob_empty); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    alloc_n(8);
    for (int c = 0; c < 3; c++) begin
      set_cdb(0, 2 * c + 1, 32'(c));
      set_cdb(1, 2 * c + 2, 32'(c + 16));
      tick();
    end
    idle();
    tick();
    tick();
    #1;
    n_total++; if (rob_count !== 4'd2) $display("FAIL wrap_after_commit: got %0d want 2", rob_count); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1;
      #1;
      n_total++; if (alloc_tag !== 4'(i + 1)) $display("FAIL wrap_tag%0d: got %0d want %0d", i, alloc_tag, i + 1); else n_pass++;
      tick();
    end
    alloc_valid = 1'b0;
    #1;
    n_total++; if (alloc_tag !== 4'd5) $display("FAIL wrap_tail: got %0d want 5", alloc_tag); else n_pass++;
    n_total++; if (rob_count !== 4'd6) $display("FAIL wrap_count: got %0d want 6", rob_count); else n_pass++;
  endtask

  task automatic test_mispredict();
    do_reset();
    alloc_n(6);
    mispredict     = 1'b1;
    mispredict_tag = 4'd3;
    alloc_valid    = 1'b1;
    tick();
    idle();
    #1;
    n_total++; if (rob_count !== 4'd3) $display("FAIL mp_count: got %0d want 3", rob_count); else n_pass++;
    n_total++; if (alloc_tag !== 4'd4) $display("FAIL mp_tail: got %0d want 4", alloc_tag); else n_pass++;
    mispredict     = 1'b1;
    mispredict_tag = 4'd6;
    tick();
    idle();
    #1;
    n_total++; if ({rob_count, alloc_tag} !== {4'd3, 4'd4})
      $display("FAIL mp_invalid_tag: got count %0d tail %0d want 3 4", rob_count, alloc_tag); else n_pass++;
    set_cdb(0, 1, 32'h101);
    set_cdb(1, 5, 32'h505);
    tick();
    idle();
    set_cdb(0, 2, 32'h202);
    set_cdb(1, 3, 32'h303);
    #1;
    n_total++; if (commit_valid !== 2'b01) $display("FAIL mp_cv1: got %b want 01", commit_valid); else n_pass++;
    tick();
    idle();
    #1;
    n_total++; if (commit_valid !== 2'b11) $display("FAIL mp_cv2: got %b want 11", commit_valid); else n_pass++;
    tick();
    #1;
    n_total++; if ({rob_empty, alloc_tag} !== {1'b1, 4'd4})
      $display("FAIL mp_drained: got empty %b tail %0d want 1 4", rob_empty, alloc_tag); else n_pass++;
  endtask

  task automatic test_cdb_collision();
    do_reset();
    alloc_n(2);
    set_cdb(0, 1, 32'h5);
    tick();
    idle();
    set_cdb(0, 2, 32'hA);
    set_cdb(1, 2, 32'hB);
    tick();
    idle();
    #1;
    n_total++; if ({commit_valid, commit_tag[3:0], commit_value[31:0]} !== {2'b01, 4'd2, 32'hB})
      $display("FAIL collision: got cv %b tag %0d val %h want 01 2 b", commit_valid, commit_tag[3:0], commit_value[31:0]); else n_pass++;
    tick();
  endtask

  task automatic test_flush_mid(input bit use_reset);
    do_reset();
    alloc_n(5);
    set_cdb(0, 1, 32'h1);
    set_cdb(1, 2, 32'h2);
    tick();
    idle();
    if (use_reset) reset = 1'b1; else flush = 1'b1;
    alloc_valid    = 1'b1;
    mispredict     = 1'b1;
    mispredict_tag = 4'd3;
    set_cdb(0, 3, 32'h3);
    #1;
    n_total++; if (commit_valid !== 2'b00) $display("FAIL squash%0d_cv: got %b want 00", use_reset, commit_valid); else n_pass++;
    if (use_reset) begin
      n_total++; if ({alloc_ready, alloc_tag} !== {1'b1, 4'd1})
        $display("FAIL rst_mid_alloc: got ready %b tag %0d want 1 1", alloc_ready, alloc_tag); else n_pass++;
    end
    tick();
    idle();
    reset = 1'b0;
    #1;
    n_total++; if ({rob_count, rob_empty, alloc_tag, commit_valid} !== {4'd0, 1'b1, 4'd1, 2'b00})
      $display("FAIL squash%0d_after: got count %0d empty %b tag %0d cv %b want 0 1 1 00",
               use_reset, rob_count, rob_empty, alloc_tag, commit_valid); else n_pass++;
  endtask

  task automatic test_random();
    ent_t        q[$];
    logic [3:0]  m_tail;
    int          pre_size;
    int          pos;
    int          n;
    logic [1:0]  e_cv;
    logic [3:0]  t;
    do_reset();
    m_tail = 4'd1;
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 199) == 0);
      flush       = ($urandom_range(0, 99) == 0);
      alloc_valid = ($urandom_range(0, 9) < 6);
      alloc_rd    = 5'($urandom);
      alloc_pc    = {$urandom, $urandom};
      for (int p = 0; p < CP; p++) begin
        cdb_valid[p] = 1'($urandom_range(0, 1));
        if (q.size() > 0 && $urandom_range(0, 3) != 0) t = q[$urandom_range(0, q.size() - 1)].tag;
        else t = 4'($urandom_range(0, RS));
        cdb_tag[p*TW +: TW]   = t;
        cdb_value[p*DW +: DW] = $urandom;
      end
      mispredict = ($urandom_range(0, 24) == 0);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) mispredict_tag = q[$urandom_range(0, q.size() - 1)].tag;
      else mispredict_tag = 4'($urandom_range(1, RS));
      #1;
      pre_size = q.size();
      n_total++; if ({alloc_ready, alloc_tag} !== {(reset || pre_size < RS), (reset ? 4'd1 : m_tail)})
        $display("FAIL rnd_alloc c%0d: got ready %b tag %0d want %b %0d", c, alloc_ready, alloc_tag,
                 (reset || pre_size < RS), (reset ? 4'd1 : m_tail)); else n_pass++;
      n_total++; if ({rob_count, rob_full, rob_empty} !== {4'(pre_size), pre_size == RS, pre_size == 0})
        $display("FAIL rnd_count c%0d: got %0d full %b empty %b want %0d", c, rob_count, rob_full, rob_empty, pre_size); else n_pass++;
      pos = -1;
      if (!reset && !flush && mispredict)
        for (int j = 0; j < q.size(); j++) if (q[j].tag == mispredict_tag) pos = j;
      if (pos >= 0) while (q.size() > pos + 1) void'(q.pop_back());
      n = 0;
      if (!reset && !flush) while (n < CW && n < q.size() && q[n].done) n++;
      e_cv = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
      n_total++; if (commit_valid !== e_cv) $display("FAIL rnd_cv c%0d: got %b want %b", c, commit_valid, e_cv); else n_pass++;
      for (int k = 0; k < n; k++) begin
        n_total++; if ({commit_tag[k*TW +: TW], commit_rd[k*5 +: 5], commit_value[k*DW +: DW]} !== {q[k].tag, q[k].rd, q[k].value})
          $display("FAIL rnd_slot%0d c%0d: got tag %0d rd %0d val %h want %0d %0d %h", k, c, commit_tag[k*TW +: TW],
                   commit_rd[k*5 +: 5], commit_value[k*DW +: DW], q[k].tag, q[k].rd, q[k].value); else n_pass++;
      end
      if (reset || flush) begin
        q.delete();
        m_tail = 4'd1;
      end else begin
        for (int p = 0; p < CP; p++)
          if (cdb_valid[p])
            for (int j = 0; j < q.size(); j++)
              if (q[j].tag == cdb_tag[p*TW +: TW]) begin
                q[j].done  = 1'b1;
                q[j].value = cdb_value[p*DW +: DW];
              end
        for (int k = 0; k < n; k++) void'(q.pop_front());
        if (pos >= 0) m_tail = 4'(int'(mispredict_tag) % RS + 1);
        else if (alloc_valid && pre_size < RS) begin
          q.push_back('{tag: m_tail, rd: alloc_rd, value: 32'h0, done: 1'b0});
          m_tail = 4'(int'(m_tail) % RS + 1);
        end
      end
      tick();
    end
    idle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_fill();
    test_ooo_writeback();
    test_wrap();
    test_mispredict();
    test_cdb_collision();
    test_flush_mid(1'b0);
    test_flush_mid(1'b1);
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_SIZE, default 16, entry count, 2..64.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, result width.
REQ-003 SHALL have parameter CDB_PORTS, default 2, writeback ports.
REQ-004 SHALL have parameter COMMIT_WIDTH, default 2, max retirements per cycle, 1..4.
REQ-005 SHALL have localparam TW = $clog2(ROB_SIZE+1), tag/count width; tags are 1..ROB_SIZE, 0 = no tag.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port alloc_valid  in  1  dispatch requests an entry.
REQ-009 SHALL have ports alloc_rd  in  5, alloc_pc  in  64  destination register and PC of the dispatched instruction.
REQ-010 SHALL have port alloc_ready  out  1  entry available.
REQ-011 SHALL have port alloc_tag  out  TW  tag granted on a handshake.
REQ-012 SHALL have ports cdb_valid  in  CDB_PORTS, cdb_tag  in  CDB_PORTS*TW, cdb_value  in  CDB_PORTS*DATA_WIDTH  result broadcast.
REQ-013 SHALL have ports mispredict  in  1, mispredict_tag  in  TW  squash everything younger than that tag.
REQ-014 SHALL have port flush  in  1  discard all entries.
REQ-015 SHALL have ports commit_valid  out  COMMIT_WIDTH, commit_tag  out  COMMIT_WIDTH*TW, commit_rd  out  COMMIT_WIDTH*5, commit_value  out  COMMIT_WIDTH*DATA_WIDTH; slot 0 is oldest.
REQ-016 SHALL have ports rob_count  out  TW, rob_full  out  1, rob_empty  out  1.

Function
REQ-017 SHALL store per entry: valid, done, rd, pc, value; entry i carries tag i+1.
REQ-018 SHALL keep head and tail tags, each 1..ROB_SIZE, incremented as t % ROB_SIZE + 1 (wrap ROB_SIZE -> 1).
REQ-019 SHALL drive alloc_ready = (rob_count < ROB_SIZE) and alloc_tag = tail combinationally from registered state only.
REQ-020 SHALL on alloc_valid && alloc_ready write entry tail (valid=1, done=0) and advance tail at the edge; alloc_valid while !alloc_ready is ignored.
REQ-021 SHALL on each cdb_valid[p] set done and value of entry cdb_tag[p] only if that entry is valid; tag 0 or an invalid entry is ignored.
REQ-022 SHALL give higher port index priority when two CDB ports write the same tag in one cycle.
REQ-023 SHALL assert commit_valid[k] combinationally for the k+1 oldest consecutive valid&&done entries from head, stopping at the first not-done entry, capped at COMMIT_WIDTH.
REQ-024 SHALL at the edge clear committed entries and advance head by the commit count.
REQ-025 SHALL not forward a CDB write to commit in the same cycle; earliest commit is the cycle after writeback.
REQ-026 SHALL update rob_count = count + allocs - commits - squashed each cycle; rob_full = (count == ROB_SIZE), rob_empty = (count == 0), registered.
REQ-027 SHALL on mispredict clear valid on every entry strictly younger than mispredict_tag and set tail = mispredict_tag % ROB_SIZE + 1; alloc is ignored that cycle; commits proceed.
REQ-028 SHALL ignore mispredict when mispredict_tag names an invalid entry.
REQ-029 SHALL on flush clear all valid bits, head = tail = 1, count = 0; suppress commit_valid that cycle; flush overrides alloc, CDB and mispredict.
REQ-030 SHALL allow simultaneous alloc and commit; when full, alloc waits one cycle even if a commit frees an entry in the same cycle.

Reset
REQ-031 SHALL on reset at the edge clear every entry, head = tail = 1, rob_count = 0, rob_empty = 1, rob_full = 0.
REQ-032 SHALL drive commit_valid = 0, alloc_ready = 1, alloc_tag = 1 during and after a reset cycle, including reset asserted mid-operation.

Verification
REQ-033 SHALL verify fill: ROB_SIZE=8, 8 allocs -> tags 1..8, rob_full=1, alloc_ready=0; 9th alloc ignored, count stays 8.
REQ-034 SHALL verify out-of-order writeback: alloc 1..3, CDB tag 3 then tag 1 -> next cycle commit tag 1 only; CDB tag 2 -> next cycle commit_valid=2'b11, tags 2,3.
REQ-035 SHALL verify wrap: 8 allocs, commit 1..6, 4 allocs -> tags 1,2,3,4 reissued, tail=5, count=6.
REQ-036 SHALL verify mispredict: valid tags 1..6, mispredict_tag=3 -> tags 4..6 invalid, tail=4, count=3, next alloc_tag=4.
REQ-037 SHALL verify same-tag CDB collision: ports 0 and 1 write tag 2 with 0xA and 0xB -> committed value 0xB.
REQ-038 SHALL verify flush and reset mid-operation with 5 valid, 2 done -> no commit that cycle, count=0, alloc_tag=1 next cycle.
